// File: rtl/regfile_mp.sv
// Multi-port integer register file: N combinational read ports with write bypass,
// two prioritised write ports, post-reset clear sweep and a registered write-conflict flag.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     wr_conflict
);

    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               conflict_nxt;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic               active;
    logic               wv0, wv1;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
    endfunction

    // Writes and bypass only count while the file is usable and reset is not asserted.
    assign active = (state == RUN) && rst;
    assign wv0    = active && we0 && addr_ok(waddr0);
    assign wv1    = active && we1 && addr_ok(waddr1);
    assign ready  = (state == RUN);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT;
            cnt         <= '0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wr_conflict <= conflict_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        conflict_nxt = 1'b0;
        unique case (state)
            INIT: begin
                if (cnt == CNT_W'(NUM_REGS - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: conflict_nxt = wv0 && wv1 && (waddr0 == waddr1);
            default: state_nxt = INIT;
        endcase
    end

    // NOTE: the array has no reset; the INIT sweep clears it, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            regs[cnt] <= '0;
        end else begin
            if (wv0) regs[waddr0] <= wdata0;
            // Later assignment wins, so port 1 takes a same-address collision.
            if (wv1) regs[waddr1] <= wdata1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (active && re[i] && addr_ok(ra)) begin
                if (we1 && waddr1 == ra)      rd = wdata1;
                else if (we0 && waddr0 == ra) rd = wdata0;
                else                          rd = regs[ra];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (4 read ports): clear sweep timing, bypass, write
// priority/conflict, register-zero writes and sweep restart on mid-sweep reset.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int RD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [RD-1:0]    re;
    logic [RD*AW-1:0] raddr;
    logic [RD*DW-1:0] rdata;
    logic             wr_conflict;

    int n_total = 0;
    int n_pass  = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic                  we0;
        logic [AW-1:0]         wa0;
        logic [DW-1:0]         wd0;
        logic                  we1;
        logic [AW-1:0]         wa1;
        logic [DW-1:0]         wd1;
        logic [RD-1:0]         re;
        logic [RD-1:0][AW-1:0] ra;
        logic [RD-1:0][DW-1:0] exp;
        logic                  conf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(string name,
                                 logic w0, logic [AW-1:0] a0w, logic [DW-1:0] d0,
                                 logic w1, logic [AW-1:0] a1w, logic [DW-1:0] d1,
                                 logic [RD-1:0] ren,
                                 logic [AW-1:0] r0, logic [AW-1:0] r1,
                                 logic [AW-1:0] r2, logic [AW-1:0] r3,
                                 logic [DW-1:0] e0, logic [DW-1:0] e1,
                                 logic [DW-1:0] e2, logic [DW-1:0] e3,
                                 logic conf);
        vec_t v;
        v.name = name;
        v.we0 = w0; v.wa0 = a0w; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1w; v.wd1 = d1;
        v.re = ren;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        v.conf = conf;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0;
    endtask

    task automatic set_rd0(input logic [AW-1:0] a);
        re = 4'b0001;
        raddr = '0;
        raddr[AW-1:0] = a;
    endtask

    // Counts rising edges until ready is seen; leaves time at posedge+1.
    task automatic count_to_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 100);
    endtask

    initial begin
        int n;

        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_conflict", {31'b0, wr_conflict}, 32'd0);
        set_rd0(5'd5);
        #1 check("reset_rdata", rdata[DW-1:0], 32'd0);
        idle_inputs();

        // Test 1: sweep length after release
        rst = 1'b1;
        count_to_ready(n);
        check("sweep_edges", n, 32'd32);
        for (int r = 1; r < NR; r++) begin
            set_rd0(AW'(r));
            #1;
            if (rdata[DW-1:0] !== 32'd0) check($sformatf("clear_reg%0d", r), rdata[DW-1:0], 32'd0);
        end
        set_rd0(5'd31);
        #1 check("clear_reg31_final", rdata[DW-1:0], 32'd0);
        @(posedge clk); #1;

        // Tests 2, 3, 4, 6 as per-cycle vectors
        vecs.push_back(row("bypass5",     1, 5, 32'hDEADBEEF, 0, 0, 0,           4'b0001, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(row("stored5",     0, 0, 0,            0, 0, 0,           4'b0001, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(row("conf_bypass", 1, 7, 32'h11,       1, 7, 32'h22,      4'b0011, 7, 5, 0, 0, 32'h22, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(row("conf_after",  0, 0, 0,            0, 0, 0,           4'b0001, 7, 0, 0, 0, 32'h22, 0, 0, 0, 1));
        vecs.push_back(row("conf_clear",  0, 0, 0,            0, 0, 0,           4'b0001, 7, 0, 0, 0, 32'h22, 0, 0, 0, 0));
        vecs.push_back(row("wr_zero",     1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row("zero_next",   0, 0, 0,            0, 0, 0,           4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row("re_off",      1, 5, 32'h55,       0, 0, 0,           4'b0000, 5, 5, 5, 5, 0, 0, 0, 0, 0));
        vecs.push_back(row("re_off_wr",   0, 0, 0,            0, 0, 0,           4'b0001, 5, 0, 0, 0, 32'h55, 0, 0, 0, 0));
        vecs.push_back(row("setup12",     1, 1, 32'h101,      1, 2, 32'h202,     4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row("setup34",     1, 3, 32'h303,      1, 4, 32'h404,     4'b1111, 1, 2, 3, 4, 32'h101, 32'h202, 32'h303, 32'h404, 0));
        vecs.push_back(row("four_port",   0, 0, 0,            1, 3, 32'hCAFE0003, 4'b1111, 1, 2, 3, 4, 32'h101, 32'h202, 32'hCAFE0003, 32'h404, 0));
        vecs.push_back(row("four_stored", 0, 0, 0,            0, 0, 0,           4'b1111, 1, 2, 3, 4, 32'h101, 32'h202, 32'hCAFE0003, 32'h404, 0));
        vecs.push_back(row("wr6",         1, 6, 32'h66,       0, 0, 0,           4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row("rd6",         0, 0, 0,            0, 0, 0,           4'b0010, 0, 6, 0, 0, 0, 32'h66, 0, 0, 0));

        foreach (vecs[k]) begin
            we0 = vecs[k].we0; waddr0 = vecs[k].wa0; wdata0 = vecs[k].wd0;
            we1 = vecs[k].we1; waddr1 = vecs[k].wa1; wdata1 = vecs[k].wd1;
            re = vecs[k].re;
            raddr = vecs[k].ra;
            #3;
            for (int p = 0; p < RD; p++)
                check($sformatf("%s_p%0d", vecs[k].name, p), rdata[p*DW +: DW], vecs[k].exp[p]);
            check({vecs[k].name, "_conf"}, {31'b0, wr_conflict}, {31'b0, vecs[k].conf});
            @(posedge clk); #1;
        end
        idle_inputs();

        // Test 5: reset while in RUN with a conflicting write pending
        set_rd0(5'd5);
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'hAAAA;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hBBBB;
        rst = 1'b0;
        #1 check("rst_low_rdata", rdata[DW-1:0], 32'd0);
        @(posedge clk); #1;
        check("rst_run_ready", {31'b0, ready}, 32'd0);
        check("rst_run_conflict", {31'b0, wr_conflict}, 32'd0);
        idle_inputs();
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("mid_sweep_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Restarted sweep; try to write low registers late in INIT.
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 20) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
                we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h44;
                set_rd0(5'd3);
                #1 check("init_bypass_blocked", rdata[DW-1:0], 32'd0);
            end
            if (n == 24) idle_inputs();
        end while (!ready && n < 100);
        check("restart_sweep_edges", n, 32'd32);
        check("restart_conflict", {31'b0, wr_conflict}, 32'd0);

        set_rd0(5'd3);
        #1 check("init_write_dropped", rdata[DW-1:0], 32'd0);
        set_rd0(5'd6);
        #1 check("run_reg6_cleared", rdata[DW-1:0], 32'd0);
        set_rd0(5'd5);
        #1 check("run_reg5_cleared", rdata[DW-1:0], 32'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
